// File: rtl/ets_pkg.sv
// ets_pkg -- shared definitions for the equivalent-time sampling controller.
//
// Holds the sequencer state encoding and the default trigger-wait timeout.
// The timeout constant is only used when the design is built with the
// ETS_TIMEOUT_EN macro defined.
package ets_pkg;

  // Default trigger-wait timeout in clk cycles.
  localparam int TMO_CYC_DEFAULT = 65535;

  // Sequencer states. The encoding is fixed so that it stays stable across
  // debug taps and older readback tooling.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_EDLY   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4
  } ets_state_e;

endpackage

// File: rtl/ets_dcnt.sv
// ets_dcnt -- loadable down-counter with a zero flag.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset, clears the count
//   load     in   load load_val this cycle (has priority over en)
//   en       in   decrement by one; the count saturates at zero
//   load_val in   W-bit value to load
//   zero     out  count is zero
//
// One instance is shared by the per-point delay and the holdoff wait,
// which never overlap in time.
module ets_dcnt
  import ets_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ets_sampler_ctrl.sv
// ets_sampler_ctrl -- equivalent-time sampling sequencer.
//
// After a start request, the controller waits for a trigger rising edge for
// each point, delays the sample strobe by idx*cfg_step cycles, fires a
// one-cycle sp_en with the point index, then waits cfg_holdoff cycles
// before re-arming. done pulses once when the last point has been sampled.
//
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   start          one-cycle request to begin a sequence (ignored while busy)
//   abort          terminate a running sequence, no done pulse
//   trigger        synchronous trigger, rising edges only
//   cfg_npts       points per sequence       (latched on accepted start)
//   cfg_step       delay step per point      (latched on accepted start)
//   cfg_holdoff    cycles after each sample  (latched on accepted start)
//   sp_en, sp_idx  sample strobe and index of the sampled point
//   busy           sequencer not idle
//   done           one-cycle completion pulse
//   err_timeout    sticky trigger-wait timeout flag
//
// Build option: define ETS_TIMEOUT_EN to abandon a sequence when no trigger
// edge arrives within TMO_CYC cycles of entering ARM. Without it,
// err_timeout is tied low and ARM waits indefinitely.
module ets_sampler_ctrl
  import ets_pkg::*;
#(
  parameter int NPTS_W  = 8,
  parameter int STEP_W  = 8,
  parameter int HOLD_W  = 12,
  parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              trigger,
  input  logic [NPTS_W-1:0] cfg_npts,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_holdoff,
  output logic              sp_en,
  output logic [NPTS_W-1:0] sp_idx,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  // The delay product needs the full NPTS_W+STEP_W width; the shared
  // counter must hold either that or a holdoff value.
  localparam int DW = NPTS_W + STEP_W;
  localparam int CW = (DW > HOLD_W) ? DW : HOLD_W;

  ets_state_e        state, state_nx;
  logic              trig_q;
  logic              trig_rise;
  logic [NPTS_W-1:0] idx;
  logic [NPTS_W-1:0] npts_q;
  logic [STEP_W-1:0] step_q;
  logic [HOLD_W-1:0] hold_q;
  logic [DW-1:0]     dly_full;
  logic [CW-1:0]     dly_cw;
  logic              cnt_load, cnt_en, cnt_zero;
  logic [CW-1:0]     cnt_val;
  logic              accept, idx_inc, done_nx;

  // trig_q resets high so a trigger already high at reset release is not
  // mistaken for a fresh edge.
  assign trig_rise = trigger & ~trig_q;

  assign dly_full = {{STEP_W{1'b0}}, idx} * {{NPTS_W{1'b0}}, step_q};
  assign dly_cw   = CW'(dly_full);

  assign sp_en = (state == ST_SAMPLE);
  assign busy  = (state != ST_IDLE);

`ifdef ETS_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_set;
`endif

  // The counter is loaded with N-1 so that the state spends exactly N
  // cycles in EDLY/HOLD before the zero flag releases it.
  ets_dcnt #(.W(CW)) u_dcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    accept   = 1'b0;
    idx_inc  = 1'b0;
    done_nx  = 1'b0;
`ifdef ETS_TIMEOUT_EN
    err_set  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          if (cfg_npts == '0) done_nx = 1'b1;
          else                state_nx = ST_ARM;
        end
      end
      ST_ARM: begin
        if (trig_rise) begin
          if (dly_cw == '0) begin
            state_nx = ST_SAMPLE;
          end else begin
            state_nx = ST_EDLY;
            cnt_load = 1'b1;
            cnt_val  = dly_cw - 1'b1;
          end
        end
`ifdef ETS_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          err_set  = 1'b1;
        end
`endif
      end
      ST_EDLY: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (idx == npts_q - 1'b1) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          idx_inc = 1'b1;
          if (hold_q == '0) begin
            state_nx = ST_ARM;
          end else begin
            state_nx = ST_HOLD;
            cnt_load = 1'b1;
            cnt_val  = CW'(hold_q) - 1'b1;
          end
        end
      end
      ST_HOLD: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_nx = ST_ARM;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Abort silently drops a running sequence: no done, no flag change.
    if (abort && (state != ST_IDLE)) begin
      state_nx = ST_IDLE;
      cnt_load = 1'b0;
      idx_inc  = 1'b0;
      done_nx  = 1'b0;
`ifdef ETS_TIMEOUT_EN
      err_set  = 1'b0;
`endif
    end
  end

  // Sequencer state, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      trig_q <= 1'b1;
      idx    <= '0;
      npts_q <= '0;
      step_q <= '0;
      hold_q <= '0;
      sp_idx <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      trig_q <= trigger;
      done   <= done_nx;
      if (accept) begin
        npts_q <= cfg_npts;
        step_q <= cfg_step;
        hold_q <= cfg_holdoff;
        idx    <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (state_nx == ST_SAMPLE) sp_idx <= idx;
    end
  end

`ifdef ETS_TIMEOUT_EN
  // The wait counter runs only in ARM and is zero on every ARM entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != ST_ARM) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + 1'b1;
      if (accept)       err_timeout <= 1'b0;
      else if (err_set) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/ets_sampler_ctrl.md
ETS_SAMPLER_CTRL -- requirements
Module: ets_sampler_ctrl

Interface
REQ-001 Parameter NPTS_W, 8, width of the point count and point index.
REQ-002 Parameter STEP_W, 8, width of the per-point delay step.
REQ-003 Parameter HOLD_W, 12, width of the holdoff count.
REQ-004 Parameter TMO_CYC, 65535, trigger-wait timeout in clk cycles; used only with ETS_TIMEOUT_EN.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin an acquisition sequence.
REQ-008 abort  in  1  terminate the sequence in progress.
REQ-009 trigger  in  1  synchronous trigger; only rising edges count.
REQ-010 cfg_npts  in  NPTS_W  points per sequence, latched on accepted start.
REQ-011 cfg_step  in  STEP_W  delay increment per point in cycles, latched on accepted start.
REQ-012 cfg_holdoff  in  HOLD_W  cycles after each sample before re-arm, latched on accepted start.
REQ-013 sp_en  out  1  one-cycle sample strobe.
REQ-014 sp_idx  out  NPTS_W  index of the current point, valid while sp_en=1.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse at sequence completion.
REQ-017 err_timeout  out  1  sticky flag: trigger wait timed out.

Function
REQ-018 States: IDLE, ARM, EDLY, SAMPLE, HOLD.
REQ-019 Edge detect: trig_q registers trigger every cycle; edge = trigger & ~trig_q.
REQ-020 IDLE: start=1 and abort=0 latches cfg, clears idx and err_timeout, enters ARM; cfg_npts=0 stays IDLE, pulses done next cycle.
REQ-021 ARM: edge enters EDLY with down-count D = idx*cfg_step at full NPTS_W+STEP_W width without truncation; D=0 enters SAMPLE directly.
REQ-022 EDLY: decrements D each cycle, enters SAMPLE after exactly D cycles in EDLY.
REQ-023 Latency: sp_en is high exactly 1+D cycles after the clock edge at which the trigger edge is sampled.
REQ-024 SAMPLE: lasts one cycle, sp_en=1, sp_idx=idx.
REQ-025 After SAMPLE: idx=cfg_npts-1 enters IDLE with done high the next cycle; else idx increments and the FSM enters HOLD (cfg_holdoff=0 enters ARM directly).
REQ-026 HOLD: exactly cfg_holdoff cycles, then ARM.
REQ-027 Trigger edges outside ARM are discarded, never queued.
REQ-028 start while busy=1 is ignored; cfg inputs are don't-care outside the start cycle.
REQ-029 abort in any non-IDLE state enters IDLE next cycle: no sp_en, no done, err_timeout unchanged; abort wins over a simultaneous start.
REQ-030 sp_idx holds its last value outside SAMPLE; sp_en and done are never high together.

Reset
REQ-031 rst_n=0: state IDLE; sp_en, sp_idx, busy, done, err_timeout, idx, counters, latched cfg all 0; trig_q=1, so a trigger held high at reset release does not fire.
REQ-032 Reset mid-sequence overrides abort and start, with no done pulse.

Configuration
REQ-033 Macro ETS_TIMEOUT_EN defined: ARM counts cycles without an edge; on reaching TMO_CYC it enters IDLE, sets err_timeout and pulses done; the count clears on ARM entry.
REQ-034 ETS_TIMEOUT_EN undefined: no timeout counter, err_timeout tied 0, ARM waits indefinitely.

Structure
REQ-035 Package ets_pkg holds the state enum typedef and the TMO_CYC default constant.
REQ-036 One sub-module ets_dcnt: a loadable down-counter with a zero flag, parameterised by width and shared by EDLY and HOLD (mutually exclusive).

Verification
REQ-037 npts=4, step=3, holdoff=2, edges every 30 cycles -> sp_en 1,4,7,10 cycles after the respective edges; sp_idx 0..3; done one cycle after the 4th sp_en.
REQ-038 start with npts=0 -> done pulse next cycle, no sp_en, busy stays 0.
REQ-039 npts=8, abort during EDLY at idx=2 -> IDLE next cycle, no sp_en, no done; a restart begins at sp_idx=0.
REQ-040 trigger held high across reset release and edges during HOLD -> no sample until a fresh rising edge arrives in ARM.
REQ-041 ETS_TIMEOUT_EN with TMO_CYC=100, no trigger -> done and err_timeout=1 exactly 100 cycles after ARM entry; the next start clears err_timeout.
REQ-042 npts=255, step=255 -> idx 254 sample arrives 64771 cycles after its edge; no truncation.
